// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC waveform playback sequencer.
package dac_seq_pkg;

    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned MAIN_STATE_W = 32;
    localparam int unsigned CHANNEL_W    = 6;
    localparam int unsigned LOOP_CNT_W   = 16;

    localparam logic [MAIN_STATE_W-1:0] DEF_UPDATE_STATE = MAIN_STATE_W'(0);
    localparam logic [SAMPLE_W-1:0]     DEF_BASELINE     = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2
    } seq_state_e;

    // One frame strobe per amplifier frame: the update state on channel 0.
    function automatic logic frame_strobe(
        input logic [MAIN_STATE_W-1:0] main_state,
        input logic [CHANNEL_W-1:0]    channel,
        input logic [MAIN_STATE_W-1:0] update_state
    );
        return (main_state == update_state) && (channel == '0);
    endfunction

endpackage

// File: rtl/dac_stim_sequencer_if.sv
// Host/frame-timing bus between the DAC datapath and the stimulus sequencer.
interface dac_stim_sequencer_if
    import dac_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
);
    logic [MAIN_STATE_W-1:0] main_state;
    logic [CHANNEL_W-1:0]    channel;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [SAMPLE_W-1:0]     wr_data;
    logic [ADDR_W:0]         seq_len;
    logic                    loop_en;
    logic                    trigger;
    logic                    stop;

    logic [SAMPLE_W-1:0]     DAC_sequencer_in;
    logic                    use_sequencer;
    logic                    busy;
    logic                    done;
    logic                    wr_err;
    logic [ADDR_W-1:0]       sample_index;
    logic [LOOP_CNT_W-1:0]   loop_count;

    modport master (
        output main_state, channel, wr_en, wr_addr, wr_data,
               seq_len, loop_en, trigger, stop,
        input  DAC_sequencer_in, use_sequencer, busy, done,
               wr_err, sample_index, loop_count
    );

    modport slave (
        input  main_state, channel, wr_en, wr_addr, wr_data,
               seq_len, loop_en, trigger, stop,
        output DAC_sequencer_in, use_sequencer, busy, done,
               wr_err, sample_index, loop_count
    );
endinterface

// File: rtl/dac_seq_ram.sv
// Sample RAM: one write port, one synchronous read port, no reset on contents.
module dac_seq_ram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/dac_stim_sequencer.sv
// Waveform playback controller: plays preloaded RAM samples into the DAC
// sequencer input, one sample per amplifier frame strobe.
module dac_stim_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned              ADDR_W       = 10,
    parameter logic [MAIN_STATE_W-1:0]  UPDATE_STATE = DEF_UPDATE_STATE,
    parameter logic [SAMPLE_W-1:0]      BASELINE     = DEF_BASELINE
) (
    input  logic                 dataclk,
    input  logic                 reset,
    dac_stim_sequencer_if.slave  bus
);
    localparam int unsigned      LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    seq_state_e              r_state;
    seq_state_e              w_state_nxt;

    logic                    r_trig_q;
    logic                    r_loop_en;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_wr_err;
    logic [ADDR_W-1:0]       r_last;
    logic [ADDR_W-1:0]       r_idx;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [SAMPLE_W-1:0]     r_dac;
    logic [LOOP_CNT_W-1:0]   r_loop_cnt;

    logic                    w_strobe;
    logic                    w_trig_edge;
    logic                    w_len_ok;
    logic                    w_ram_we;
    logic                    w_loop_en_nxt;
    logic                    w_done_nxt;
    logic                    w_wr_err_nxt;
    logic [ADDR_W-1:0]       w_last_nxt;
    logic [ADDR_W-1:0]       w_idx_nxt;
    logic [ADDR_W-1:0]       w_idx_inc;
    logic [ADDR_W-1:0]       w_rd_addr_nxt;
    logic [SAMPLE_W-1:0]     w_dac_nxt;
    logic [SAMPLE_W-1:0]     w_rd_data;
    logic [LOOP_CNT_W-1:0]   w_loop_cnt_nxt;

    // Index following idx within the armed sequence, wrapping after the last.
    function automatic logic [ADDR_W-1:0] next_idx(
        input logic [ADDR_W-1:0] idx,
        input logic [ADDR_W-1:0] last
    );
        return (idx == last) ? '0 : idx + ADDR_W'(1);
    endfunction

    assign w_strobe    = frame_strobe(bus.main_state, bus.channel, UPDATE_STATE);
    assign w_trig_edge = bus.trigger & ~r_trig_q;
    assign w_len_ok    = (bus.seq_len != '0) && (bus.seq_len <= MAX_LEN);
    assign w_ram_we    = bus.wr_en && (r_state == ST_IDLE);
    assign w_idx_inc   = r_idx + ADDR_W'(1);

    dac_seq_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clk       (dataclk),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read address rests at 0 in IDLE so mem[0] is already on the read port
    // when the first strobe after arming arrives.
    always_comb begin
        w_state_nxt    = r_state;
        w_dac_nxt      = r_dac;
        w_idx_nxt      = r_idx;
        w_rd_addr_nxt  = r_rd_addr;
        w_last_nxt     = r_last;
        w_loop_en_nxt  = r_loop_en;
        w_loop_cnt_nxt = r_loop_cnt;
        w_done_nxt     = 1'b0;
        w_wr_err_nxt   = bus.wr_en && (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                w_rd_addr_nxt = '0;
                if (w_trig_edge && !bus.stop && w_len_ok) begin
                    w_state_nxt    = ST_ARMED;
                    w_last_nxt     = ADDR_W'(bus.seq_len - LEN_W'(1));
                    w_loop_en_nxt  = bus.loop_en;
                    w_loop_cnt_nxt = '0;
                end
            end

            ST_ARMED: begin
                if (bus.stop) begin
                    w_state_nxt   = ST_IDLE;
                    w_dac_nxt     = BASELINE;
                    w_rd_addr_nxt = '0;
                end else if (w_strobe) begin
                    w_state_nxt   = ST_PLAY;
                    w_dac_nxt     = w_rd_data;
                    w_idx_nxt     = '0;
                    w_rd_addr_nxt = next_idx('0, r_last);
                end
            end

            ST_PLAY: begin
                if (bus.stop) begin
                    w_state_nxt   = ST_IDLE;
                    w_dac_nxt     = BASELINE;
                    w_rd_addr_nxt = '0;
                end else if (w_strobe) begin
                    if (r_idx == r_last) begin
                        if (r_loop_en) begin
                            w_dac_nxt      = w_rd_data;
                            w_idx_nxt      = '0;
                            w_rd_addr_nxt  = next_idx('0, r_last);
                            w_loop_cnt_nxt = (r_loop_cnt == '1) ? r_loop_cnt
                                           : r_loop_cnt + LOOP_CNT_W'(1);
                        end else begin
                            w_state_nxt   = ST_IDLE;
                            w_dac_nxt     = BASELINE;
                            w_rd_addr_nxt = '0;
                            w_done_nxt    = 1'b1;
                        end
                    end else begin
                        w_dac_nxt     = w_rd_data;
                        w_idx_nxt     = w_idx_inc;
                        w_rd_addr_nxt = next_idx(w_idx_inc, r_last);
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_dac_nxt     = BASELINE;
                w_rd_addr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            r_trig_q   <= 1'b0;
            r_dac      <= BASELINE;
            r_idx      <= '0;
            r_rd_addr  <= '0;
            r_last     <= '0;
            r_loop_en  <= 1'b0;
            r_loop_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_trig_q   <= bus.trigger;
            r_dac      <= w_dac_nxt;
            r_idx      <= w_idx_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_last     <= w_last_nxt;
            r_loop_en  <= w_loop_en_nxt;
            r_loop_cnt <= w_loop_cnt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= w_done_nxt;
            r_wr_err   <= w_wr_err_nxt;
        end
    end

    assign bus.DAC_sequencer_in = r_dac;
    assign bus.use_sequencer    = r_busy;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.wr_err           = r_wr_err;
    assign bus.sample_index     = r_idx;
    assign bus.loop_count       = r_loop_cnt;

endmodule
